// File: rtl/mem_stage_pkg.sv
// Shared RV64 defines for the memory stage: widths, opcodes, size codes, helpers.
package mem_stage_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned INST_LEN = 32;

  // instr[6:2] major opcode codes
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // funct3[1:0] access size codes
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [INST_LEN-1:0] NOP_ENC = 32'h0000_0013;

  function automatic logic is_load(input logic [INST_LEN-1:0] instr);
    return instr[6:2] == OP_LOAD;
  endfunction

  function automatic logic is_store(input logic [INST_LEN-1:0] instr);
    return instr[6:2] == OP_STORE;
  endfunction

  // Byte-enable pattern for an access of the given size at offset 0
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // True when the offset is not a multiple of the access size
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: req/gnt request phase, rvalid response phase.
interface mem_stage_if #(
  parameter int unsigned XLEN = mem_stage_pkg::XLEN
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [7:0]      wmask;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: shift the addressed field down and sign/zero-extend it.
module lsu_load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = mem_stage_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] lsres_o
);

  logic [XLEN-1:0] field;
  logic            uns;

  // Extract field at byte offset, then extend by size/signedness
  always_comb begin
    field   = rdata_i >> {off_i, 3'b000};
    uns     = funct3_i[2];
    lsres_o = field;
    case (funct3_i[1:0])
      SZ_B: lsres_o = {{(XLEN-8){~uns & field[7]}},   field[7:0]};
      SZ_H: lsres_o = {{(XLEN-16){~uns & field[15]}}, field[15:0]};
      SZ_W: lsres_o = {{(XLEN-32){~uns & field[31]}}, field[31:0]};
      default: lsres_o = field;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues loads/stores, aligns load data, feeds writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned      XLEN      = mem_stage_pkg::XLEN,
  parameter logic [31:0]      NOP_INSTR = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   alures_i,
  input  logic [XLEN-1:0]   stdata_i,
  input  logic [XLEN-1:0]   csrdata_i,
  mem_stage_if.master       mem,
  output logic              wb_valid_o,
  output logic [XLEN-1:0]   wb_pc_o,
  output logic [31:0]       wb_instr_o,
  output logic [XLEN-1:0]   wb_alures_o,
  output logic [XLEN-1:0]   wb_lsres_o,
  output logic [XLEN-1:0]   wb_csrdata_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_alures_q, hold_alures_d;
  logic [XLEN-1:0] hold_stdata_q, hold_stdata_d;
  logic [XLEN-1:0] hold_csrdata_q, hold_csrdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_pc_q, wb_pc_d;
  logic [31:0]     wb_instr_q, wb_instr_d;
  logic [XLEN-1:0] wb_alures_q, wb_alures_d;
  logic [XLEN-1:0] wb_lsres_q, wb_lsres_d;
  logic [XLEN-1:0] wb_csrdata_q, wb_csrdata_d;
  logic            misalign_q, misalign_d;

  logic            in_mem_op;
  logic            in_misal;
  logic            done;
  logic [XLEN-1:0] load_res;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i  (mem.rdata),
    .off_i    (hold_alures_q[2:0]),
    .funct3_i (hold_instr_q[14:12]),
    .lsres_o  (load_res)
  );

  // Memory port driven from the held op so it stays stable until granted
  always_comb begin
    mem.req   = (state_q == S_REQ);
    mem.we    = (state_q == S_REQ) && is_store(hold_instr_q);
    mem.addr  = {hold_alures_q[XLEN-1:3], 3'b000};
    mem.wdata = hold_stdata_q << {hold_alures_q[2:0], 3'b000};
    mem.wmask = size_mask(hold_instr_q[13:12]) << hold_alures_q[2:0];
  end

  assign in_ready_o   = (state_q == S_IDLE);
  assign wb_valid_o   = wb_valid_q;
  assign wb_pc_o      = wb_pc_q;
  assign wb_instr_o   = wb_instr_q;
  assign wb_alures_o  = wb_alures_q;
  assign wb_lsres_o   = wb_lsres_q;
  assign wb_csrdata_o = wb_csrdata_q;
  assign misalign_o   = misalign_q;

  // Next-state and writeback register update; default each cycle is a bubble
  always_comb begin
    state_d        = state_q;
    hold_pc_d      = hold_pc_q;
    hold_instr_d   = hold_instr_q;
    hold_alures_d  = hold_alures_q;
    hold_stdata_d  = hold_stdata_q;
    hold_csrdata_d = hold_csrdata_q;
    wb_valid_d     = 1'b0;
    wb_pc_d        = wb_pc_q;
    wb_instr_d     = NOP_INSTR;
    wb_alures_d    = wb_alures_q;
    wb_lsres_d     = wb_lsres_q;
    wb_csrdata_d   = wb_csrdata_q;
    misalign_d     = 1'b0;
    done           = 1'b0;

    in_mem_op = is_load(instr_i) || is_store(instr_i);
    in_misal  = misaligned(alures_i[2:0], instr_i[13:12]);

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (in_mem_op && !in_misal) begin
            hold_pc_d      = pc_i;
            hold_instr_d   = instr_i;
            hold_alures_d  = alures_i;
            hold_stdata_d  = stdata_i;
            hold_csrdata_d = csrdata_i;
            state_d        = S_REQ;
          end else begin
            wb_valid_d   = 1'b1;
            wb_pc_d      = pc_i;
            wb_instr_d   = instr_i;
            wb_alures_d  = alures_i;
            wb_lsres_d   = '0;
            wb_csrdata_d = csrdata_i;
            misalign_d   = in_mem_op;
          end
        end
      end
      S_REQ: begin
        if (mem.gnt) begin
          if (mem.rvalid) done = 1'b1;
          else            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.rvalid) done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      state_d      = S_IDLE;
      wb_valid_d   = 1'b1;
      wb_pc_d      = hold_pc_q;
      wb_instr_d   = hold_instr_q;
      wb_alures_d  = hold_alures_q;
      wb_lsres_d   = is_store(hold_instr_q) ? '0 : load_res;
      wb_csrdata_d = hold_csrdata_q;
    end
  end

  // State, holding and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      hold_pc_q      <= '0;
      hold_instr_q   <= '0;
      hold_alures_q  <= '0;
      hold_stdata_q  <= '0;
      hold_csrdata_q <= '0;
      wb_valid_q     <= 1'b0;
      wb_pc_q        <= '0;
      wb_instr_q     <= NOP_INSTR;
      wb_alures_q    <= '0;
      wb_lsres_q     <= '0;
      wb_csrdata_q   <= '0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_pc_q      <= hold_pc_d;
      hold_instr_q   <= hold_instr_d;
      hold_alures_q  <= hold_alures_d;
      hold_stdata_q  <= hold_stdata_d;
      hold_csrdata_q <= hold_csrdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_pc_q        <= wb_pc_d;
      wb_instr_q     <= wb_instr_d;
      wb_alures_q    <= wb_alures_d;
      wb_lsres_q     <= wb_lsres_d;
      wb_csrdata_q   <= wb_csrdata_d;
      misalign_q     <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, stalls, misalign, reset.
module tb_mem_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_LB   = 32'h00030283;
  localparam logic [31:0] I_LH   = 32'h00031283;
  localparam logic [31:0] I_LW   = 32'h00032283;
  localparam logic [31:0] I_LD   = 32'h00033283;
  localparam logic [31:0] I_LBU  = 32'h00034283;
  localparam logic [31:0] I_SH   = 32'h00731023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] pc = '0;
  logic [31:0] instr = NOP;
  logic [63:0] alures = '0;
  logic [63:0] stdata = '0;
  logic [63:0] csrdata = '0;
  logic        wb_valid;
  logic [63:0] wb_pc, wb_alures, wb_lsres, wb_csrdata;
  logic [31:0] wb_instr;
  logic        misalign;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_stage_if #(.XLEN(64)) mif ();

  mem_stage #(.XLEN(64), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .pc_i         (pc),
    .instr_i      (instr),
    .alures_i     (alures),
    .stdata_i     (stdata),
    .csrdata_i    (csrdata),
    .mem          (mif),
    .wb_valid_o   (wb_valid),
    .wb_pc_o      (wb_pc),
    .wb_instr_o   (wb_instr),
    .wb_alures_o  (wb_alures),
    .wb_lsres_o   (wb_lsres),
    .wb_csrdata_o (wb_csrdata),
    .misalign_o   (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One aligned load/store with gnt withheld gnt_delay cycles; same_cycle gives gnt+rvalid together
  task automatic mem_op(input string tag, input logic [31:0] ins, input logic [63:0] addr_in,
                        input logic [63:0] sdata, input int unsigned gnt_delay, input bit same_cycle,
                        input logic [63:0] rdata, input logic [63:0] exp_lsres,
                        input logic [63:0] exp_addr, input logic exp_we,
                        input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
    @(negedge clk);
    in_valid = 1'b1; instr = ins; alures = addr_in; stdata = sdata; pc = pc + 64'd4;
    mif.gnt = 1'b0; mif.rvalid = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; instr = I_ADD; alures = 64'hDEAD;
    check_eq({tag, " bubble wb_valid"}, {63'd0, wb_valid}, 64'd0);
    check_eq({tag, " bubble wb_instr"}, {32'd0, wb_instr}, {32'd0, NOP});
    for (int i = 0; i < int'(gnt_delay); i++) begin
      check_eq({tag, " stall req"}, {63'd0, mif.req}, 64'd1);
      check_eq({tag, " stall addr"}, mif.addr, exp_addr);
      check_eq({tag, " stall in_ready"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    check_eq({tag, " req"}, {63'd0, mif.req}, 64'd1);
    check_eq({tag, " addr"}, mif.addr, exp_addr);
    check_eq({tag, " we"}, {63'd0, mif.we}, {63'd0, exp_we});
    check_eq({tag, " in_ready req"}, {63'd0, in_ready}, 64'd0);
    if (exp_we) begin
      check_eq({tag, " wdata"}, mif.wdata, exp_wdata);
      check_eq({tag, " wmask"}, {56'd0, mif.wmask}, {56'd0, exp_mask});
    end
    mif.gnt = 1'b1;
    if (same_cycle) begin
      mif.rvalid = 1'b1; mif.rdata = rdata;
    end else begin
      @(negedge clk);
      mif.gnt = 1'b0;
      check_eq({tag, " wait req"}, {63'd0, mif.req}, 64'd0);
      check_eq({tag, " in_ready wait"}, {63'd0, in_ready}, 64'd0);
      mif.rvalid = 1'b1; mif.rdata = rdata;
    end
    @(negedge clk);
    mif.gnt = 1'b0; mif.rvalid = 1'b0;
    check_eq({tag, " wb_valid"}, {63'd0, wb_valid}, 64'd1);
    check_eq({tag, " wb_instr"}, {32'd0, wb_instr}, {32'd0, ins});
    check_eq({tag, " wb_alures"}, wb_alures, addr_in);
    check_eq({tag, " wb_lsres"}, wb_lsres, exp_lsres);
    check_eq({tag, " in_ready done"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = '0;

    // Reset state
    #12;
    check_eq("rst wb_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("rst wb_instr", {32'd0, wb_instr}, {32'd0, NOP});
    check_eq("rst mem_req", {63'd0, mif.req}, 64'd0);
    check_eq("rst in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst misalign", {63'd0, misalign}, 64'd0);
    check_eq("rst wb_alures", wb_alures, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU ops
    @(negedge clk);
    in_valid = 1'b1; instr = I_ADD; alures = 64'h1234; pc = 64'h100; csrdata = 64'h77;
    check_eq("add in_ready0", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    check_eq("add1 wb_valid", {63'd0, wb_valid}, 64'd1);
    check_eq("add1 wb_alures", wb_alures, 64'h1234);
    check_eq("add1 wb_pc", wb_pc, 64'h100);
    check_eq("add1 wb_csr", wb_csrdata, 64'h77);
    check_eq("add1 wb_lsres", wb_lsres, 64'd0);
    check_eq("add1 in_ready", {63'd0, in_ready}, 64'd1);
    alures = 64'h5678; pc = 64'h104;
    @(negedge clk);
    check_eq("add2 wb_valid", {63'd0, wb_valid}, 64'd1);
    check_eq("add2 wb_alures", wb_alures, 64'h5678);
    check_eq("add2 in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("idle wb_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("idle wb_instr", {32'd0, wb_instr}, {32'd0, NOP});

    // Loads and stores
    mem_op("lb", I_LB, 64'h80000003, 64'd0, 0, 1'b0, 64'h00000000_80FF7F00,
           64'hFFFFFFFF_FFFFFF80, 64'h80000000, 1'b0, 64'd0, 8'h00);
    mem_op("lbu", I_LBU, 64'h80000003, 64'd0, 0, 1'b0, 64'h00000000_80FF7F00,
           64'h00000000_00000080, 64'h80000000, 1'b0, 64'd0, 8'h00);
    mem_op("sh", I_SH, 64'h80000006, 64'hABCD, 0, 1'b0, 64'd0,
           64'd0, 64'h80000000, 1'b1, 64'hABCD0000_00000000, 8'hC0);
    mem_op("ld", I_LD, 64'h80000010, 64'd0, 3, 1'b0, 64'h11223344_55667788,
           64'h11223344_55667788, 64'h80000010, 1'b0, 64'd0, 8'h00);
    mem_op("lw", I_LW, 64'h80000024, 64'd0, 0, 1'b0, 64'h87654321_00000000,
           64'hFFFFFFFF_87654321, 64'h80000020, 1'b0, 64'd0, 8'h00);
    mem_op("lh same", I_LH, 64'h80000002, 64'd0, 1, 1'b1, 64'h00000000_80010000,
           64'hFFFFFFFF_FFFF8001, 64'h80000000, 1'b0, 64'd0, 8'h00);

    // Misaligned LW is retired without a memory request
    @(negedge clk);
    in_valid = 1'b1; instr = I_LW; alures = 64'h80000002;
    check_eq("mis req0", {63'd0, mif.req}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mis req1", {63'd0, mif.req}, 64'd0);
    check_eq("mis pulse", {63'd0, misalign}, 64'd1);
    check_eq("mis wb_valid", {63'd0, wb_valid}, 64'd1);
    check_eq("mis wb_lsres", wb_lsres, 64'd0);
    check_eq("mis wb_alures", wb_alures, 64'h80000002);
    @(negedge clk);
    check_eq("mis pulse end", {63'd0, misalign}, 64'd0);

    // Reset asserted while waiting for a response
    in_valid = 1'b1; instr = I_LD; alures = 64'h80000040;
    @(negedge clk);
    in_valid = 1'b0; mif.gnt = 1'b1;
    @(negedge clk);
    mif.gnt = 1'b0;
    check_eq("wait in_ready", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst wb_alures", wb_alures, 64'd0);
    check_eq("arst wb_instr", {32'd0, wb_instr}, {32'd0, NOP});
    check_eq("arst in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst req", {63'd0, mif.req}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mif.rvalid = 1'b1; mif.rdata = 64'hFFFF;
    @(negedge clk);
    mif.rvalid = 1'b0;
    check_eq("stale rvalid", {63'd0, wb_valid}, 64'd0);
    in_valid = 1'b1; instr = I_ADD; alures = 64'h99;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("post rst wb_valid", {63'd0, wb_valid}, 64'd1);
    check_eq("post rst alures", wb_alures, 64'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
